// File: rtl/uart_receiver_if.sv
// uart_receiver_if -- signal bundle between the UART receiver and its CPU-side user.
//
//   i_rx        serial line, asynchronous, idles high
//   i_read      pop strobe; consumes the FIFO head when o_valid=1
//   i_clear     clears the sticky o_overrun / o_frame_err flags
//   o_data      FIFO head byte (meaningful only while o_valid=1)
//   o_valid     FIFO non-empty
//   o_overrun   sticky: a received byte was dropped because the FIFO was full
//   o_frame_err sticky: a stop bit was sampled low
//   o_dbg_state receiver FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP, 4 BREAK)
//
// Handshake: o_valid/i_read follow valid/ready rules. A pop happens on a rising
// clk edge where o_valid=1 and i_read=1; i_read while o_valid=0 has no effect,
// and o_data only carries meaning while o_valid=1.
interface uart_receiver_if;
  logic       i_rx;
  logic       i_read;
  logic       i_clear;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_overrun;
  logic       o_frame_err;
  logic [2:0] o_dbg_state;

  modport slave (
    input  i_rx, i_read, i_clear,
    output o_data, o_valid, o_overrun, o_frame_err, o_dbg_state
  );

  modport master (
    output i_rx, i_read, i_clear,
    input  o_data, o_valid, o_overrun, o_frame_err, o_dbg_state
  );
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver -- 8N1 serial receiver feeding a first-word-fall-through FIFO.
//
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    uart_receiver_if.slave (line input, pop/clear strobes, FIFO head,
//          sticky status flags, FSM debug state)
//
// The line is double-flopped; everything downstream uses the synchronized rx_s.
// Sampling points (cycles after the first cycle rx_s=0): start bit at HALF,
// data bit k at HALF+(k+1)*DIV, stop bit at HALF+9*DIV.
module uart_receiver #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD_RATE   = 1000000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            reset,
  uart_receiver_if.slave  bus
);

  localparam int DIV  = CLK_FREQ_HZ / BAUD_RATE;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int NW   = AW + 1;

  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [NW-1:0] FULL_CNT  = NW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BRK   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          sync1_q, sync1_d;
  logic          rx_s_q, rx_s_d;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [NW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d;

  logic push, frame_set, pop, full, wr_en, ovr_set;

  // Receiver FSM: next state, bit counters and push/frame-error pulses.
  always_comb begin
    sync1_d   = bus.i_rx;
    rx_s_d    = sync1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          // A line already back high at mid-start-bit was a glitch.
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          // LSB arrives first, so shift in at the top.
          shift_d = {rx_s_q, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = S_BRK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BRK: begin
        // Held-low line: wait for idle so only one framing error is raised.
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO and sticky flags. A push into a full FIFO still lands when the head
  // is popped in the same cycle, since a slot frees up at that edge.
  always_comb begin
    pop      = bus.i_read && (count_q != '0);
    full     = (count_q == FULL_CNT);
    wr_en    = push && (!full || pop);
    ovr_set  = push && full && !pop;
    mem_d    = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = shift_q;
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + NW'(wr_en) - NW'(pop);
    // Set has priority over a simultaneous clear.
    overrun_d   = ovr_set   ? 1'b1 : (bus.i_clear ? 1'b0 : overrun_q);
    frame_err_d = frame_set ? 1'b1 : (bus.i_clear ? 1'b0 : frame_err_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sync1_q     <= sync1_d;
      rx_s_q      <= rx_s_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign bus.o_valid     = (count_q != '0);
  assign bus.o_data      = bus.o_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign bus.o_overrun   = overrun_q;
  assign bus.o_frame_err = frame_err_q;
  assign bus.o_dbg_state = state_q;

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver for the SOC IO page, the receive-side counterpart of the existing UART transmitter. Samples an asynchronous 8N1 line, assembles bytes, and queues them in a small first-word-fall-through FIFO. The CPU reads queued bytes through memory-mapped IO. Sticky status flags report overrun and framing errors.

## Interface
- CLK_FREQ_HZ, 100000000, clock frequency in Hz.
- BAUD_RATE, 1000000, line bit rate.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, 2..16.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- i_rx  in  1  asynchronous serial input; idles high.
- i_read  in  1  pop strobe. When o_valid=1, it consumes the head entry at that edge.
- i_clear  in  1  clears o_overrun and o_frame_err.
- o_data  out  8  FIFO head byte. Defined only while o_valid=1.
- o_valid  out  1  FIFO non-empty.
- o_overrun  out  1  sticky flag: a byte was dropped because the FIFO was full.
- o_frame_err  out  1  sticky flag: a stop bit was sampled low.

## Operation
- DIV = CLK_FREQ_HZ/BAUD_RATE, integer truncation. HALF = DIV/2. DIV must be at least 8. The baud counter is $clog2(DIV) bits wide.
- i_rx passes through a 2-flop synchronizer. The synchronizer resets to 1. All logic uses the synchronized value rx_s.
- FSM states:
  - IDLE: waits for rx_s=0, then goes to START and loads the counter.
  - START: counts HALF cycles, then samples rx_s. A 0 goes to DATA. A 1 is a glitch and returns to IDLE with no flag.
  - DATA: samples every DIV cycles, 8 bits, LSB first, into a shift register. After bit 7 goes to STOP.
  - STOP: samples after DIV cycles.
    - rx_s=1: push the byte and return to IDLE.
    - rx_s=0: set o_frame_err, discard the byte, go to BREAK.
  - BREAK: waits for rx_s=1, then goes to IDLE. A held-low line produces exactly one framing error.
- Push when the FIFO is full: the byte is dropped and o_overrun is set. FIFO contents are unchanged.
- Push and pop in the same cycle when full: both succeed, and o_overrun is not set.
- Push and pop in the same cycle when empty: o_valid stays 0 in that cycle. The byte is pushed and becomes the head at the next cycle.
- i_read while o_valid=0 is ignored.
- Sticky flags: if a set and i_clear happen in the same cycle, the set wins.
- FIFO uses read and write pointers plus a count. Pointers wrap modulo FIFO_DEPTH.
- SOC mapping: a new word-address bit IO_UART_RX_bit = 3.
  - A read returns {20'b0, o_frame_err, o_overrun, o_valid, 1'b0, o_data}.
  - A load from that address asserts i_read.
  - A write to that address asserts i_clear.

## Timing
- Reset (synchronous, one cycle) puts the design in this state:
  - FSM in IDLE, counter 0, FIFO empty.
  - o_valid=0, o_data=8'h00, o_overrun=0, o_frame_err=0.
  - Synchronizer flops at 1.
- Reset mid-frame abandons the frame. The partial byte is lost, and no flag is set.
- Sampling points, measured in cycles after the first cycle rx_s=0:
  - start bit: HALF
  - data bit k: HALF+(k+1)*DIV
  - stop bit: HALF+9*DIV
- Latency: o_valid rises 1 cycle after the stop-bit sample, which is 2 cycles after the synchronizer input.
- o_frame_err and o_overrun rise 1 cycle after the stop-bit sample.
- A pop is visible the next cycle: o_data shows the new head, or o_valid=0 if the FIFO is now empty.
- Back-to-back frames: a new start edge is accepted the cycle after STOP returns to IDLE.
- Baud tolerance: at least ±3% with DIV ≥ 16.

## Test plan
- Single byte: CLK_FREQ_HZ=16, BAUD_RATE=1 (DIV=16). Drive 8'hA5 as 8N1 -> o_valid=1 with o_data=8'hA5, exactly HALF+9*DIV+3 cycles after i_rx falls. Flags stay 0.
- Glitch: pulse i_rx low for 4 cycles -> FSM returns to IDLE, o_valid stays 0, no flags.
- Overrun: send 5 bytes 8'h01..8'h05 with no reads, FIFO_DEPTH=4 -> o_overrun=1. Reads return 01,02,03,04, then o_valid=0. Then i_clear -> o_overrun=0.
- Full with simultaneous pop: FIFO holds 4 bytes. Pulse i_read in the cycle of the 5th byte's push -> no overrun. Reads return bytes 2..5.
- Framing and break: send 8'h3C with the stop bit low, then hold i_rx low for 40 bit times -> exactly one o_frame_err and no push. After i_rx returns high, 8'h7E is received correctly.
- Reset mid-frame: assert reset after data bit 3 of 8'hFF, then send 8'h42 -> only 8'h42 is received, no flags.
